// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types, constants and datapath step functions for the
// iterative HI/LO multiply/divide unit.
//   multdiv_op_t    : operation encoding as presented by the execute stage
//   multdiv_state_t : controller states
//   mul_step        : one shift-add multiply iteration on the {HI,LO} accumulator
//   div_step        : one restoring-division iteration on {remainder,quotient}
//   neg32 / neg64   : two's-complement negate
//   abs32           : magnitude of a signed 32-bit operand
package multdiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } multdiv_op_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MULTIPLY = 3'd1,
    DIVIDE   = 3'd2,
    SIGN_FIX = 3'd3,
    DONE     = 3'd4
  } multdiv_state_t;

  localparam int ITERATIONS = 32;

  // acc = {partial product, remaining multiplier bits}. The add carry becomes
  // the new top bit once the whole accumulator shifts right.
  function automatic logic [63:0] mul_step(input logic [63:0] acc,
                                           input logic [31:0] mcand);
    logic [32:0] upper;
    upper = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    return {upper, acc[31:1]};
  endfunction

  // acc = {remainder, dividend bits still to consume / quotient bits so far}.
  // partial is 33 bits wide because the shifted remainder can reach 2*divisor-1.
  function automatic logic [63:0] div_step(input logic [63:0] acc,
                                           input logic [31:0] divisor);
    logic [32:0] partial;
    logic [32:0] diff;
    partial = {acc[63:32], acc[31]};
    diff    = partial - {1'b0, divisor};
    if (!diff[32]) begin
      return {diff[31:0], acc[30:0], 1'b1};
    end
    return {partial[31:0], acc[30:0], 1'b0};
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return (~v) + 64'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative MULT/MULTU/DIV/DIVU controller for the HI/LO path.
// Stalls the front of the pipeline for 32 iterations plus a sign-fix cycle,
// then presents registered HI/LO results with a one-cycle write strobe.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   start_execute                 : mult/div instruction valid in execute
//   operation_execute[1:0]        : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   source_a_execute / _b_execute : rs (multiplicand/dividend), rt (multiplier/divisor)
//   stall_pipeline                : holds fetch/decode/execute while busy
//   hi_lo_register_write_execute  : one-cycle strobe, HI/LO valid
//   ALU_HI_output_execute         : upper product or remainder
//   ALU_LO_output_execute         : lower product or quotient
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_execute,
  input  logic [1:0]       operation_execute,
  input  logic [WIDTH-1:0] source_a_execute,
  input  logic [WIDTH-1:0] source_b_execute,
  output logic             stall_pipeline,
  output logic             hi_lo_register_write_execute,
  output logic [WIDTH-1:0] ALU_HI_output_execute,
  output logic [WIDTH-1:0] ALU_LO_output_execute
);

  multdiv_state_t state_q, state_d;
  multdiv_op_t    op_q, op_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [63:0]    acc_q, acc_d;
  logic [31:0]    opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic           neg_q, neg_d;       // product / quotient sign
  logic           rem_neg_q, rem_neg_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;

  logic           signed_op;
  logic [31:0]    a_mag;
  logic [31:0]    b_mag;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    signed_op = ~operation_execute[0];
    a_mag     = signed_op ? abs32(source_a_execute) : source_a_execute;
    b_mag     = signed_op ? abs32(source_b_execute) : source_b_execute;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_execute) begin
          op_d      = multdiv_op_t'(operation_execute);
          neg_d     = signed_op & (source_a_execute[31] ^ source_b_execute[31]);
          rem_neg_d = signed_op & source_a_execute[31];
          if (operation_execute[1]) begin
            acc_d  = {32'd0, a_mag};
            opnd_d = b_mag;
            if (source_b_execute == '0) begin
              // Divide by zero bypasses iteration; HI returns the raw dividend.
              hi_d    = source_a_execute;
              lo_d    = '1;
              state_d = DONE;
            end else begin
              state_d = DIVIDE;
            end
          end else begin
            acc_d   = {32'd0, b_mag};
            opnd_d  = a_mag;
            state_d = MULTIPLY;
          end
        end
      end
      MULTIPLY: begin
        acc_d = mul_step(acc_q, opnd_q);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITERATIONS - 1)) state_d = SIGN_FIX;
      end
      DIVIDE: begin
        acc_d = div_step(acc_q, opnd_q);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITERATIONS - 1)) state_d = SIGN_FIX;
      end
      SIGN_FIX: begin
        if (op_q == DIV || op_q == DIVU) begin
          lo_d = neg_q     ? neg32(acc_q[31:0])  : acc_q[31:0];
          hi_d = rem_neg_q ? neg32(acc_q[63:32]) : acc_q[63:32];
        end else begin
          {hi_d, lo_d} = neg_q ? neg64(acc_q) : acc_q;
        end
        state_d = DONE;
      end
      DONE: begin
        // start_execute still reflects the instruction being retired here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign stall_pipeline = ((state_q == IDLE) && start_execute) ||
                          (state_q == MULTIPLY) || (state_q == DIVIDE) ||
                          (state_q == SIGN_FIX);
  assign hi_lo_register_write_execute = (state_q == DONE);
  assign ALU_HI_output_execute        = hi_q;
  assign ALU_LO_output_execute        = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Testbench for multdiv_unit: directed vector table plus hand-written
// sequences for reset, mid-operation reset and back-to-back starts.
module tb_multdiv_unit;
  import multdiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_execute;
  logic [1:0]  operation_execute;
  logic [31:0] source_a_execute;
  logic [31:0] source_b_execute;
  logic        stall_pipeline;
  logic        hi_lo_register_write_execute;
  logic [31:0] ALU_HI_output_execute;
  logic [31:0] ALU_LO_output_execute;

  multdiv_unit #(.WIDTH(32)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .start_execute                (start_execute),
    .operation_execute            (operation_execute),
    .source_a_execute             (source_a_execute),
    .source_b_execute             (source_b_execute),
    .stall_pipeline               (stall_pipeline),
    .hi_lo_register_write_execute (hi_lo_register_write_execute),
    .ALU_HI_output_execute        (ALU_HI_output_execute),
    .ALU_LO_output_execute        (ALU_LO_output_execute)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input vec_t v);
    int got;
    logic stall_ok;
    @(negedge clk);
    start_execute     = 1'b1;
    operation_execute = v.op;
    source_a_execute  = v.a;
    source_b_execute  = v.b;
    #1;
    chk({v.name, " stall_c0"}, 64'(stall_pipeline), 64'd1);
    got      = -1;
    stall_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (hi_lo_register_write_execute) begin
        got = c;
        break;
      end
      if (!stall_pipeline) stall_ok = 1'b0;
    end
    chk({v.name, " latency"}, 64'(got), 64'(v.lat));
    chk({v.name, " stall_busy"}, 64'(stall_ok), 64'd1);
    if (got >= 0) begin
      chk({v.name, " hi"}, 64'(ALU_HI_output_execute), 64'(v.hi));
      chk({v.name, " lo"}, 64'(ALU_LO_output_execute), 64'(v.lo));
      chk({v.name, " stall_done"}, 64'(stall_pipeline), 64'd0);
    end
    start_execute = 1'b0;
    @(negedge clk);
    chk({v.name, " strobe_once"}, 64'(hi_lo_register_write_execute), 64'd0);
    chk({v.name, " stall_idle"}, 64'(stall_pipeline), 64'd0);
    chk({v.name, " hold"}, {ALU_HI_output_execute, ALU_LO_output_execute}, {v.hi, v.lo});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int strobes;
    int first_c;
    int second_c;

    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, "multu_max"};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, "mult_neg3x7"};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, "div_neg7_2"};
    vecs[3]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       34, "divu_100_7"};
    vecs[4]  = '{DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1,  "divu_by0"};
    vecs[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, "div_ovf"};
    vecs[6]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34, "mult_minmin"};
    vecs[7]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34, "div_7_neg2"};
    vecs[8]  = '{MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 34, "multu_shift"};
    vecs[9]  = '{DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1,  "div_by0_neg"};
    vecs[10] = '{MULT,  32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 34, "mult_zero"};

    reset             = 1'b1;
    start_execute     = 1'b0;
    operation_execute = 2'b00;
    source_a_execute  = '0;
    source_b_execute  = '0;
    repeat (2) @(negedge clk);
    chk("reset stall",  64'(stall_pipeline), 64'd0);
    chk("reset strobe", 64'(hi_lo_register_write_execute), 64'd0);
    chk("reset hilo",   {ALU_HI_output_execute, ALU_LO_output_execute}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset during a MULT: asserted in cycle 10, effective on the next edge.
    @(negedge clk);
    start_execute     = 1'b1;
    operation_execute = MULT;
    source_a_execute  = 32'd5;
    source_b_execute  = 32'd9;
    repeat (10) @(negedge clk);
    chk("midrst busy", 64'(stall_pipeline), 64'd1);
    reset         = 1'b1;
    start_execute = 1'b0;
    @(negedge clk);
    chk("midrst stall",  64'(stall_pipeline), 64'd0);
    chk("midrst strobe", 64'(hi_lo_register_write_execute), 64'd0);
    chk("midrst hilo",   {ALU_HI_output_execute, ALU_LO_output_execute}, 64'd0);
    reset   = 1'b0;
    strobes = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hi_lo_register_write_execute) strobes++;
    end
    chk("midrst no_strobe", 64'(strobes), 64'd0);

    // start held high through DONE, second MULTU issued in the following IDLE.
    @(negedge clk);
    start_execute     = 1'b1;
    operation_execute = MULTU;
    source_a_execute  = 32'd3;
    source_b_execute  = 32'd5;
    strobes  = 0;
    first_c  = -1;
    second_c = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (hi_lo_register_write_execute) begin
        strobes++;
        if (strobes == 1) begin
          first_c = c;
          chk("b2b first_lo", 64'(ALU_LO_output_execute), 64'd15);
          source_a_execute = 32'd6;
          source_b_execute = 32'd7;
        end else if (strobes == 2) begin
          second_c = c;
          chk("b2b second_lo", 64'(ALU_LO_output_execute), 64'd42);
          chk("b2b second_hi", 64'(ALU_HI_output_execute), 64'd0);
          start_execute = 1'b0;
        end
      end else if (strobes == 1 && c == first_c + 1) begin
        chk("b2b restart_stall", 64'(stall_pipeline), 64'd1);
      end
    end
    chk("b2b first_cycle",  64'(first_c),  64'd34);
    chk("b2b second_cycle", 64'(second_c), 64'd69);
    chk("b2b strobe_count", 64'(strobes),  64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative multiply/divide controller for the HI/LO path of the five-stage MIPS pipeline. It sits beside the execute-stage ALU and accepts MULT, MULTU, DIV and DIVU operations. It stalls the front of the pipeline while it iterates over 32 cycles, then presents the HI/LO results with a one-cycle write strobe. On that strobe the held instruction carries the results forward through the execute/memory and memory/writeback registers.

## Interface
Parameters:
- WIDTH, 32, operand and result width; only 32 is supported.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; returns the unit to IDLE.
- start_execute  input  1  a mult/div instruction is valid in the execute stage.
- operation_execute  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- source_a_execute  input  32  rs value: multiplicand or dividend.
- source_b_execute  input  32  rt value: multiplier or divisor.
- stall_pipeline  output  1  holds fetch, decode and execute while the unit is busy.
- hi_lo_register_write_execute  output  1  one-cycle strobe; HI/LO outputs are valid.
- ALU_HI_output_execute  output  32  HI result: upper product or remainder.
- ALU_LO_output_execute  output  32  LO result: lower product or quotient.

## Operation
FSM states: IDLE, MULTIPLY, DIVIDE, SIGN_FIX, DONE.

- **IDLE**
  - If start_execute is high, latch the operands.
  - For signed operations, latch absolute values and record the result sign:
    - product sign = sign(a) XOR sign(b)
    - quotient sign = sign(a) XOR sign(b)
    - remainder sign = sign(a)
  - Clear the 5-bit counter.
  - Go to MULTIPLY (op[1]=0) or DIVIDE (op[1]=1).
  - DIV or DIVU with b==0 goes straight to DONE with HI=a and LO=32'hFFFFFFFF.
- **MULTIPLY**: shift-add.
  - 64-bit accumulator {HI,LO}; each cycle, if the multiplier LSB is set, add the multiplicand into the upper half, then shift right by one.
  - Exit after counter==31.
- **DIVIDE**: restoring division.
  - Each cycle, shift the {remainder,quotient} pair left and trial-subtract the divisor; keep the subtraction if it is non-negative and set the quotient bit.
  - Exit after counter==31.
- **SIGN_FIX**
  - Signed operations: conditionally two's-complement negate the 64-bit product, or negate quotient and remainder independently. Quotient truncates toward zero.
  - Unsigned operations pass through unchanged.
  - 0x80000000 / -1 yields LO=0x80000000, HI=0, with no trap.
- **DONE**
  - Assert hi_lo_register_write_execute and hold the results.
  - start_execute is ignored in this state, because the same instruction is still in execute.
  - Return to IDLE.
- **Result holding**: ALU_HI_output_execute and ALU_LO_output_execute are registered and hold their last value until the next DONE.

## Timing
- **Reset values**: state IDLE, counter 0, ALU_HI/LO outputs 0, hi_lo_register_write_execute 0, stall_pipeline 0 (with start_execute low).
- **stall_pipeline** is combinational and high when either:
  - state==IDLE and start_execute==1, or
  - state is MULTIPLY, DIVIDE or SIGN_FIX.
- stall_pipeline is low in DONE, so the instruction advances on the edge that ends DONE.
- **Normal latency** (cycle 0 = IDLE with start high):
  - cycles 1–32: iterate
  - cycle 33: SIGN_FIX
  - cycle 34: DONE
  - The stall lasts 34 cycles.
- **Divide-by-zero latency**: DONE in cycle 1; the stall lasts 1 cycle.
- **Back-to-back operations**: a new operation can start in the IDLE cycle immediately after DONE.
- **Reset mid-operation**: on the next edge the unit returns to IDLE and zeroes its outputs; no write strobe is produced.

## Structure
- Package multdiv_pkg holds:
  - typedef enum logic [1:0] multdiv_op_t: MULT, MULTU, DIV, DIVU
  - typedef enum logic [2:0] multdiv_state_t
  - localparam ITERATIONS = 32
- No sub-module: the shift-add step, the restoring step and the negate are package functions used by a single always_ff / always_comb pair.
- Target size: about 200 lines of RTL.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → at cycle 34, HI=0xFFFFFFFE, LO=0x00000001, write strobe for 1 cycle, stall high for cycles 0–33.
- MULT a=-3 (0xFFFFFFFD), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV a=-7, b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU a=100, b=7 → LO=14, HI=2.
- DIVU a=0x64, b=0 → DONE at cycle 1 with HI=0x64, LO=0xFFFFFFFF; stall high only in cycle 0.
- Reset asserted at cycle 10 of a MULT → next cycle IDLE, stall low, outputs 0, no strobe.
- start_execute held high through DONE, then a second MULTU 6×7 → exactly two strobes, second result LO=42, HI=0.
